// File: rtl/input_map_pkg.sv
// Shared definitions for the memory-mapped input peripheral: register
// addresses and the bus access-size encoding used by the I/O maps.
package input_map_pkg;

    localparam logic [31:0] ADDR_SW       = 32'h0000_0000;
    localparam logic [31:0] ADDR_BTN      = 32'h0000_0004;
    localparam logic [31:0] ADDR_PEND     = 32'h0000_0008;
    localparam logic [31:0] ADDR_IRQ_MASK = 32'h0000_000C;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

endpackage

// File: rtl/input_debounce.sv
// Single-bit two-flop synchronizer followed by a counting debouncer.
// rise pulses for one cycle on the edge that moves stable from 0 to 1.
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;
    logic          done;

    assign done = (sync != stable) && (cnt == CNT_LAST);
    // Flagged on the cycle the update commits, so the pulse and the new
    // stable level take effect on the same edge.
    assign rise = done && sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
            if (sync == stable) begin
                cnt <= '0;
            end else if (done) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/input_map.sv
// Memory-mapped switch/button input block with sticky W1C press flags.
// Optional IRQ mask register and interrupt output under INPUT_MAP_IRQ_EN.
module input_map
    import input_map_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int NUM_SW          = 8,
    parameter int NUM_BTN         = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        input_address,
    input  logic [31:0]        input_in,
    input  logic [1:0]         input_size,
    input  logic               input_write_enable,
    output logic [31:0]        input_out,
    input  logic [NUM_SW-1:0]  sw,
    input  logic [NUM_BTN-1:0] btn,
    output logic               irq
);
    logic [NUM_SW-1:0]  stable_sw;
    logic [NUM_SW-1:0]  sw_rise;
    logic [NUM_BTN-1:0] stable_btn;
    logic [NUM_BTN-1:0] btn_rise;
    logic [NUM_BTN-1:0] pending;
    logic [31:0]        word_addr;
    logic [31:0]        wmask;
    logic [31:0]        wdata;
    logic [NUM_BTN-1:0] wbits;
    logic               wr_pend;
    size_e              size;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk),
            .rst    (rst),
            .raw    (sw[i]),
            .stable (stable_sw[i]),
            .rise   (sw_rise[i])
        );
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk),
            .rst    (rst),
            .raw    (btn[i]),
            .stable (stable_btn[i]),
            .rise   (btn_rise[i])
        );
    end

    assign word_addr = {input_address[31:2], 2'b00};
    assign size      = size_e'(input_size);
    assign wmask     = (size == SIZE_BYTE) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    assign wdata     = input_in & wmask;
    assign wbits     = wdata[NUM_BTN-1:0];
    assign wr_pend   = input_write_enable && (word_addr == ADDR_PEND);

    // A press arriving with a W1C of the same bit keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~(wr_pend ? wbits : '0)) | btn_rise;
        end
    end

`ifdef INPUT_MAP_IRQ_EN
    logic [NUM_BTN-1:0] irq_mask;
    logic               wr_mask;

    assign wr_mask = input_write_enable && (word_addr == ADDR_IRQ_MASK);

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_mask) begin
                irq_mask <= wbits;
            end
            irq <= |(pending & irq_mask);
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        input_out = 32'h0;
        case (word_addr)
            ADDR_SW:       input_out = 32'(stable_sw);
            ADDR_BTN:      input_out = 32'(stable_btn);
            ADDR_PEND:     input_out = 32'(pending);
`ifdef INPUT_MAP_IRQ_EN
            ADDR_IRQ_MASK: input_out = 32'(irq_mask);
`endif
            default:       input_out = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_input_map.sv
// Directed self-checking bench for input_map (default debounce of 16 cycles).
// Covers the IRQ path when built with INPUT_MAP_IRQ_EN, tie-off otherwise.
module tb_input_map;

    logic        clk;
    logic        rst;
    logic [31:0] input_address;
    logic [31:0] input_in;
    logic [1:0]  input_size;
    logic        input_write_enable;
    logic [31:0] input_out;
    logic [7:0]  sw;
    logic [3:0]  btn;
    logic        irq;

    int tests = 0;
    int fails = 0;

    input_map dut (
        .clk                (clk),
        .rst                (rst),
        .input_address      (input_address),
        .input_in           (input_in),
        .input_size         (input_size),
        .input_write_enable (input_write_enable),
        .input_out          (input_out),
        .sw                 (sw),
        .btn                (btn),
        .irq                (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  sw_val;
        logic [31:0] addr;
        logic [31:0] exp;
    } sw_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string name);
        input_address = a;
        #1;
        check(name, input_out, e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        input_address      = a;
        input_in           = d;
        input_size         = s;
        input_write_enable = 1'b1;
        tick();
        input_write_enable = 1'b0;
        input_in           = 32'h0;
        input_size         = 2'd2;
    endtask

    sw_vec_t vecs [5];
    logic [7:0] prev_sw;

    initial begin
        vecs[0] = '{8'hA5, 32'h0, 32'hA5};
        vecs[1] = '{8'h5A, 32'h3, 32'h5A};
        vecs[2] = '{8'hFF, 32'h10, 32'h0};
        vecs[3] = '{8'h3C, 32'h1, 32'h3C};
        vecs[4] = '{8'h00, 32'h4, 32'h0};

        rst                = 1'b1;
        sw                 = 8'hFF;
        btn                = 4'h0;
        input_address      = 32'h0;
        input_in           = 32'h0;
        input_size         = 2'd2;
        input_write_enable = 1'b0;

        // Reset held three cycles with switches already high
        for (int c = 0; c < 3; c++) begin
            tick();
            rd(32'h0, 32'h0, "rst_sw");
            rd(32'h4, 32'h0, "rst_btn");
            rd(32'h8, 32'h0, "rst_pend");
            rd(32'hC, 32'h0, "rst_mask");
            check("rst_irq", {31'b0, irq}, 32'h0);
        end
        rst = 1'b0;
        tick(17);
        rd(32'h0, 32'h0, "sw_lat_17");
        tick();
        rd(32'h0, 32'hFF, "sw_lat_18");

        prev_sw = 8'hFF;
        for (int v = 0; v < 5; v++) begin
            sw = vecs[v].sw_val;
            tick(17);
            rd(32'h0, {24'h0, prev_sw}, $sformatf("vec%0d_hold", v));
            tick();
            rd(vecs[v].addr, vecs[v].exp, $sformatf("vec%0d_read", v));
            rd(32'h0, {24'h0, vecs[v].sw_val}, $sformatf("vec%0d_sw", v));
            prev_sw = vecs[v].sw_val;
        end

        // Glitch on btn[0] shorter than the debounce window
        btn = 4'h1;
        for (int c = 0; c < 10; c++) begin
            tick();
            rd(32'h4, 32'h0, "glitch_btn_hi");
            rd(32'h8, 32'h0, "glitch_pend_hi");
        end
        btn = 4'h0;
        for (int c = 0; c < 20; c++) begin
            tick();
            rd(32'h4, 32'h0, "glitch_btn_lo");
            rd(32'h8, 32'h0, "glitch_pend_lo");
        end

        // Press btn[2] and release
        btn = 4'h4;
        tick(17);
        rd(32'h4, 32'h0, "press_btn_17");
        rd(32'h8, 32'h0, "press_pend_17");
        tick();
        rd(32'h4, 32'h4, "press_btn_18");
        rd(32'h8, 32'h4, "press_pend_18");
        tick(12);
        btn = 4'h0;
        tick(18);
        rd(32'h4, 32'h0, "release_btn");
        rd(32'h8, 32'h4, "release_pend");

        btn = 4'h1;
        tick(18);
        rd(32'h8, 32'h5, "pend_5");
        btn = 4'h0;
        tick(18);
        rd(32'h4, 32'h0, "btn0_released");

        // W1C behaviour and size masking
        wr(32'h8, 32'h1, 2'd2);
        rd(32'h8, 32'h4, "w1c_bit0");
        wr(32'h8, 32'h0, 2'd2);
        rd(32'h8, 32'h4, "w1c_zero");
        wr(32'h8, 32'hFFFF_FF00, 2'd0);
        rd(32'h8, 32'h4, "w1c_byte_mask");
        rd(32'h8, 32'h4, "read_no_side_effect");
        wr(32'h0, 32'hFF, 2'd2);
        rd(32'h0, 32'h0, "sw_readonly");
        wr(32'h10, 32'hF, 2'd2);
        rd(32'h8, 32'h4, "w1c_other_addr");
        wr(32'h9, 32'h4, 2'd1);
        rd(32'h8, 32'h0, "w1c_half_unaligned");

        // Press pulse and W1C of bit 1 on the same edge
        btn = 4'h2;
        tick(17);
        rd(32'h8, 32'h0, "coll_pend_before");
        wr(32'h8, 32'h2, 2'd2);
        rd(32'h8, 32'h2, "coll_pend_kept");
        rd(32'h4, 32'h2, "coll_btn");
        wr(32'h8, 32'h2, 2'd2);
        rd(32'h8, 32'h0, "coll_then_clear");
        btn = 4'h0;
        tick(18);

`ifdef INPUT_MAP_IRQ_EN
        wr(32'hC, 32'h2, 2'd2);
        rd(32'hC, 32'h2, "irq_mask_rd");
        btn = 4'h2;
        tick(18);
        rd(32'h8, 32'h2, "irq_pend_set");
        check("irq_not_yet", {31'b0, irq}, 32'h0);
        tick();
        check("irq_asserted", {31'b0, irq}, 32'h1);
        btn = 4'h0;
        wr(32'h8, 32'h2, 2'd2);
        rd(32'h8, 32'h0, "irq_pend_clr");
        tick();
        check("irq_deasserted", {31'b0, irq}, 32'h0);
        tick(18);
        btn = 4'h1;
        tick(18);
        rd(32'h8, 32'h1, "irq_pend_btn0");
        tick();
        check("irq_masked_btn0", {31'b0, irq}, 32'h0);
        btn = 4'h0;
        tick(18);
        wr(32'h8, 32'h1, 2'd2);
`else
        wr(32'hC, 32'hF, 2'd2);
        rd(32'hC, 32'h0, "nomask_rd");
        btn = 4'h2;
        tick(19);
        rd(32'h8, 32'h2, "noirq_pend");
        check("noirq_irq", {31'b0, irq}, 32'h0);
        btn = 4'h0;
        wr(32'h8, 32'h2, 2'd2);
        tick(18);
`endif

        // Reset in the middle of a debounce restarts it
        sw = 8'hFF;
        tick(10);
        rd(32'h0, 32'h0, "mid_sw_before");
        rst = 1'b1;
        tick();
        rd(32'h0, 32'h0, "mid_sw_in_rst");
        rst = 1'b0;
        tick(17);
        rd(32'h0, 32'h0, "mid_sw_17");
        tick();
        rd(32'h0, 32'hFF, "mid_sw_18");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
